// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
//   Direct-mapped, write-through, no-write-allocate data cache. It sits between
//   the single-cycle datapath's load/store port and a byte-lane data memory.
//   Load hits are answered in the same cycle. Load misses and all stores raise
//   cpu_stall while one req/ack memory transaction completes. A single RESP
//   cycle then releases the datapath.
//
// Ports
//   clk, rst_b        clock (rising edge); asynchronous reset, active-high
//   cpu_req/cpu_we    load/store request; 1 = store
//   cpu_addr          byte address, bits [1:0] ignored
//   cpu_wdata         store data
//   cpu_rdata         load data (hit: combinational; miss: in the RESP cycle)
//   cpu_stall         hold the datapath this cycle
//   invalidate_all    pulse; clears every valid bit at the next edge
//   mem_req/mem_we    registered memory request / write strobe
//   mem_addr          registered word address, [1:0] = 0
//   mem_data_in       registered write bytes; [0] = bits 31:24 ... [3] = bits 7:0
//   mem_data_out      read bytes, same lane order
//   mem_ack           memory done; read bytes are valid in this cycle
//   hit_count         saturating load-hit counter
//   miss_count        saturating load-miss counter
// -----------------------------------------------------------------------------
module data_cache #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [XLEN-1:0]      cpu_addr,
  input  logic [XLEN-1:0]      cpu_wdata,
  output logic [XLEN-1:0]      cpu_rdata,
  output logic                 cpu_stall,
  input  logic                 invalidate_all,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [0:3][7:0]      mem_data_in,
  input  logic [0:3][7:0]      mem_data_out,
  input  logic                 mem_ack,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  localparam int LINES    = 2 ** IDX_BITS;
  localparam int TAG_BITS = XLEN - IDX_BITS - 2;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE_THRU, RESP} state_t;

  state_t                state_q, state_d;

  logic [XLEN-1:0]       data_mem [LINES];
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [LINES-1:0]      valid_q;

  logic [XLEN-1:0]       rdata_q;
  logic [31:0]           hit_cnt_q, miss_cnt_q;

  logic [IDX_BITS-1:0]   cpu_idx, fill_idx;
  logic [TAG_BITS-1:0]   cpu_tag, fill_tag;
  logic                  hit;
  logic                  load_hit, load_miss, store_go, fill, mem_done;

  // Byte-offset bits take no part in the lookup.
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[1:0], mem_addr[1:0]};

  assign cpu_idx  = cpu_addr[IDX_BITS+1:2];
  assign cpu_tag  = cpu_addr[XLEN-1:IDX_BITS+2];
  // While a transaction is open, the held mem_addr is the latched miss address.
  assign fill_idx = mem_addr[IDX_BITS+1:2];
  assign fill_tag = mem_addr[XLEN-1:IDX_BITS+2];

  assign hit = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);

  assign mem_done = mem_ack && ((state_q == READ_MISS) || (state_q == WRITE_THRU));
  assign fill     = mem_ack && (state_q == READ_MISS);

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  // NOTE: every output of this block gets a default before the case statement.
  // An output that missed a default on any path would infer a latch.
  always_comb begin
    state_d   = state_q;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    load_hit  = 1'b0;
    load_miss = 1'b0;
    store_go  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            store_go  = 1'b1;
            cpu_stall = 1'b1;
            state_d   = WRITE_THRU;
          end else if (hit) begin
            load_hit  = 1'b1;
            cpu_rdata = data_mem[cpu_idx];
          end else begin
            load_miss = 1'b1;
            cpu_stall = 1'b1;
            state_d   = READ_MISS;
          end
        end
      end
      READ_MISS, WRITE_THRU: begin
        cpu_stall = 1'b1;
        if (mem_ack) state_d = RESP;
      end
      RESP: begin
        // This single non-stalled cycle lets the PC advance, so the held
        // request is not issued a second time.
        cpu_rdata = rdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      rdata_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q <= state_d;

      // A fill on the same edge wins for its own line: the later assignment
      // takes precedence.
      if (invalidate_all) valid_q <= '0;
      if (fill)           valid_q[fill_idx] <= 1'b1;

      if (load_miss) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= {cpu_addr[XLEN-1:2], 2'b00};
      end
      if (store_go) begin
        mem_req     <= 1'b1;
        mem_we      <= 1'b1;
        mem_addr    <= {cpu_addr[XLEN-1:2], 2'b00};
        mem_data_in <= cpu_wdata[31:0];
      end
      if (mem_done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end

      if (fill) rdata_q <= XLEN'(mem_data_out);

      if (load_hit  && (hit_cnt_q  != 32'hFFFF_FFFF)) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (load_miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  // NOTE: the line data and tag arrays have no reset. valid_q alone decides
  // whether a line is trusted, and leaving the arrays unreset lets them map
  // onto RAM.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[fill_idx] <= XLEN'(mem_data_out);
      tag_mem[fill_idx]  <= fill_tag;
    end else if (store_go && hit) begin
      data_mem[cpu_idx] <= cpu_wdata;
    end
  end

endmodule
